// File: rtl/nf_i_mem_resp_if.sv
// ---------------------------------------------------------------------------
// nf_i_mem_resp_if
// Bundles the instruction-fetch handshake and the instruction-RAM port seen by
// the fetch responder.
//   Fetch side : req_i, addr_i        -> responder
//                req_ack_i, instr_i,
//                misalign_o           <- responder
//   RAM side   : mem_re, mem_addr     <- responder
//                mem_rd_data          -> responder
// Modports:
//   slave  : the responder (nf_i_mem_resp)
//   master : the environment around it (fetch unit plus RAM macro)
// ---------------------------------------------------------------------------
interface nf_i_mem_resp_if #(
    parameter int ADDR_W = 10
);
    logic              req_i;
    logic [31:0]       addr_i;
    logic              req_ack_i;
    logic [31:0]       instr_i;
    logic              misalign_o;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;

    modport slave (
        input  req_i, addr_i, mem_rd_data,
        output req_ack_i, instr_i, misalign_o, mem_re, mem_addr
    );

    modport master (
        output req_i, addr_i, mem_rd_data,
        input  req_ack_i, instr_i, misalign_o, mem_re, mem_addr
    );
endinterface

// File: rtl/nf_i_mem_resp.sv
// ---------------------------------------------------------------------------
// nf_i_mem_resp
// Responder end of the instruction-fetch request/acknowledge interface.
// Captures the fetch address on a request, reads the containing word from a
// synchronous instruction RAM that needs WAIT_CYCLES+1 cycles per read, and
// returns a one-cycle acknowledge with the instruction word.
//
// Ports:
//   clk     : clock
//   resetn  : asynchronous active-low reset
//   bus     : nf_i_mem_resp_if.slave
//             req_i/addr_i        fetch request and byte address
//             req_ack_i/instr_i   one-cycle ack, word valid in the same cycle
//             misalign_o          high with the ack when addr[1:0] != 0
//             mem_re/mem_addr     RAM read enable and word address
//             mem_rd_data         RAM read data
//
// Parameters:
//   ADDR_W      : RAM word-index width (depth 2**ADDR_W), at most 29
//   WAIT_CYCLES : extra RAM latency beyond one cycle, 0..15
//   NOP_INSTR   : instr_i value after reset
// ---------------------------------------------------------------------------
module nf_i_mem_resp #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               resetn,
    nf_i_mem_resp_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q,      state_d;
    logic [ADDR_W+1:0]   addr_r_q,     addr_r_d;
    logic [3:0]          cnt_q,        cnt_d;
    logic [31:0]         instr_hold_q, instr_hold_d;
    logic                req_ack_q,    req_ack_d;
    logic                mem_re_q,     mem_re_d;
    logic                misalign_q,   misalign_d;

    // Byte-address bits above the RAM range are dropped so fetches wrap
    // modulo the RAM size.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_i[31:ADDR_W+2];

    // Outputs are decoded one cycle early so every control output comes
    // straight from a flop: req_ack_q/misalign_q are high exactly in RESP,
    // mem_re_q exactly in RD.
    always_comb begin
        state_d      = state_q;
        addr_r_d     = addr_r_q;
        cnt_d        = cnt_q;
        instr_hold_d = instr_hold_q;
        req_ack_d    = 1'b0;
        mem_re_d     = 1'b0;
        misalign_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    addr_r_d = bus.addr_i[ADDR_W+1:0];
                    state_d  = S_RD;
                    mem_re_d = 1'b1;
                end
            end

            S_RD: begin
                cnt_d = 4'(WAIT_CYCLES);
                if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d    = S_RESP;
                    req_ack_d  = 1'b1;
                    misalign_d = (addr_r_q[1:0] != 2'b00);
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    req_ack_d  = 1'b1;
                    misalign_d = (addr_r_q[1:0] != 2'b00);
                end
            end

            S_RESP: begin
                // Keep the delivered word so instr_i stays stable until the
                // next acknowledge.
                instr_hold_d = bus.mem_rd_data;
                if (bus.req_i) begin
                    addr_r_d = bus.addr_i[ADDR_W+1:0];
                    state_d  = S_RD;
                    mem_re_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            addr_r_q     <= '0;
            cnt_q        <= '0;
            instr_hold_q <= NOP_INSTR;
            req_ack_q    <= 1'b0;
            mem_re_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_r_q     <= addr_r_d;
            cnt_q        <= cnt_d;
            instr_hold_q <= instr_hold_d;
            req_ack_q    <= req_ack_d;
            mem_re_q     <= mem_re_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.req_ack_i  = req_ack_q;
    assign bus.misalign_o = misalign_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_addr   = addr_r_q[ADDR_W+1:2];
    // During the ack the RAM word passes straight through; otherwise the
    // last fetched word (or NOP after reset) is presented.
    assign bus.instr_i    = req_ack_q ? bus.mem_rd_data : instr_hold_q;

endmodule

// File: tb/tb_nf_i_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_nf_i_mem_resp
// Four responders (WAIT_CYCLES = 0, 1, 3, 15) share one fetch stimulus; each
// has its own instruction-RAM model with the matching read latency. Index k
// of the per-instance arrays maps to WAIT_CYCLES 0, 1, 3, 15.
// RAM contents: word 2 = 0x00500093, every other word a = {16'hA5A5, 6'b0, a}.
// ---------------------------------------------------------------------------
module tb_nf_i_mem_resp;

    localparam int          AW  = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic [31:0] addr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic int wc_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
        if (a == 10'd2) return 32'h0050_0093;
        return {16'hA5A5, 6'b0, a};
    endfunction

    logic          ack_v   [4];
    logic          re_v    [4];
    logic          mis_v   [4];
    logic [31:0]   ins_v   [4];
    logic [AW-1:0] maddr_v [4];
    logic [31:0]   rd_data [4] = '{default: 32'hDEAD_BEEF};
    logic [3:0]    pend    [4] = '{default: 4'd0};
    logic [AW-1:0] paddr   [4] = '{default: '0};

    nf_i_mem_resp_if #(.ADDR_W(AW)) ifs [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;

        nf_i_mem_resp #(
            .ADDR_W      (AW),
            .WAIT_CYCLES (W),
            .NOP_INSTR   (NOP)
        ) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (ifs[g])
        );

        assign ifs[g].req_i       = req;
        assign ifs[g].addr_i      = addr;
        assign ifs[g].mem_rd_data = rd_data[g];
        assign ack_v[g]           = ifs[g].req_ack_i;
        assign re_v[g]            = ifs[g].mem_re;
        assign mis_v[g]           = ifs[g].misalign_o;
        assign ins_v[g]           = ifs[g].instr_i;
        assign maddr_v[g]         = ifs[g].mem_addr;
    end

    // RAM models: data is garbage until WAIT_CYCLES+1 cycles after mem_re,
    // then held until the next read.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (re_v[k]) begin
                if (wc_of(k) == 0) begin
                    rd_data[k] <= ram_word(maddr_v[k]);
                end else begin
                    rd_data[k] <= BAD;
                    pend[k]    <= 4'(wc_of(k));
                    paddr[k]   <= maddr_v[k];
                end
            end else if (pend[k] != 4'd0) begin
                pend[k] <= pend[k] - 4'd1;
                if (pend[k] == 4'd1) rd_data[k] <= ram_word(paddr[k]);
            end
        end
    end

    int ack_cnt [4];
    int re_cnt  [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            ack_cnt[k] += 32'(ack_v[k]);
            re_cnt[k]  += 32'(re_v[k]);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            ack_cnt[k] = 0;
            re_cnt[k]  = 0;
        end
    endtask

    initial begin
        int last [4];
        int smin [4];
        int smax [4];

        resetn = 1'b0;
        req    = 1'b0;
        addr   = 32'h0;
        clr();
        tick();
        tick();

        // ---- reset state ----
        chk("rst_ack",   32'(ack_v[1]),   32'h0);
        chk("rst_instr", ins_v[1],        NOP);
        chk("rst_re",    32'(re_v[1]),    32'h0);
        chk("rst_mis",   32'(mis_v[1]),   32'h0);
        chk("rst_maddr", 32'(maddr_v[1]), 32'h0);
        resetn = 1'b1;
        tick();
        clr();

        // ---- single fetch of 0x8, WAIT_CYCLES=1 ----
        req  = 1'b1;
        addr = 32'h8;
        tick();                                   // RD
        req  = 1'b0;
        chk("t1_rd_re",    32'(re_v[1]),    32'h1);
        chk("t1_rd_maddr", 32'(maddr_v[1]), 32'h2);
        chk("t1_rd_ack",   32'(ack_v[1]),   32'h0);
        tick();                                   // WAIT
        chk("t1_wait_ack",   32'(ack_v[1]), 32'h0);
        chk("t1_wait_re",    32'(re_v[1]),  32'h0);
        chk("t1_wait_instr", ins_v[1],      NOP);
        tick();                                   // RESP
        chk("t1_resp_ack",   32'(ack_v[1]), 32'h1);
        chk("t1_resp_instr", ins_v[1],      32'h0050_0093);
        chk("t1_resp_mis",   32'(mis_v[1]), 32'h0);
        tick();                                   // IDLE
        chk("t1_idle_ack",   32'(ack_v[1]), 32'h0);
        chk("t1_hold_instr", ins_v[1],      32'h0050_0093);
        repeat (3) tick();
        chk("t1_re_count",  32'(re_cnt[1]),  32'h1);
        chk("t1_ack_count", 32'(ack_cnt[1]), 32'h1);
        chk("t1_hold_late", ins_v[1],        32'h0050_0093);
        repeat (20) tick();

        // ---- req tied high, addr 0,4,8, WAIT_CYCLES=0 ----
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("t2_pre_nop", ins_v[0], NOP);
        req  = 1'b1;
        addr = 32'h0;
        tick();                                   // RD word 0
        chk("t2_rd0_re",    32'(re_v[0]),    32'h1);
        chk("t2_rd0_maddr", 32'(maddr_v[0]), 32'h0);
        chk("t2_rd0_nop",   ins_v[0],        NOP);
        chk("t2_rd0_ack",   32'(ack_v[0]),   32'h0);
        tick();                                   // RESP word 0
        chk("t2_ack0",   32'(ack_v[0]), 32'h1);
        chk("t2_instr0", ins_v[0],      32'hA5A5_0000);
        addr = 32'h4;
        tick();                                   // RD word 1
        chk("t2_rd1_ack",   32'(ack_v[0]),   32'h0);
        chk("t2_rd1_maddr", 32'(maddr_v[0]), 32'h1);
        chk("t2_rd1_hold",  ins_v[0],        32'hA5A5_0000);
        tick();                                   // RESP word 1
        chk("t2_ack1",   32'(ack_v[0]), 32'h1);
        chk("t2_instr1", ins_v[0],      32'hA5A5_0001);
        addr = 32'h8;
        tick();                                   // RD word 2
        chk("t2_rd2_maddr", 32'(maddr_v[0]), 32'h2);
        tick();                                   // RESP word 2
        chk("t2_ack2",   32'(ack_v[0]), 32'h1);
        chk("t2_instr2", ins_v[0],      32'h0050_0093);
        req = 1'b0;
        tick();                                   // IDLE
        chk("t2_idle_ack", 32'(ack_v[0]), 32'h0);
        chk("t2_idle_re",  32'(re_v[0]),  32'h0);
        repeat (20) tick();

        // ---- throughput sweep across all four latencies ----
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        clr();
        for (int k = 0; k < 4; k++) begin
            last[k] = -1;
            smin[k] = 1000;
            smax[k] = 0;
        end
        req  = 1'b1;
        addr = 32'h10;
        for (int c = 0; c < 80; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (ack_v[k]) begin
                    if (last[k] >= 0) begin
                        if (c - last[k] < smin[k]) smin[k] = c - last[k];
                        if (c - last[k] > smax[k]) smax[k] = c - last[k];
                    end
                    last[k] = c;
                end
            end
        end
        req = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_w%0d_acks_ge2", wc_of(k)), 32'(ack_cnt[k] >= 2), 32'h1);
            chk($sformatf("sweep_w%0d_min_gap", wc_of(k)), 32'(smin[k]), 32'(wc_of(k) + 2));
            chk($sformatf("sweep_w%0d_max_gap", wc_of(k)), 32'(smax[k]), 32'(wc_of(k) + 2));
            chk($sformatf("sweep_w%0d_re_per_ack", wc_of(k)), 32'(re_cnt[k]), 32'(ack_cnt[k]));
        end

        // ---- wrap and misalign: 0x1002 with ADDR_W=10, WAIT_CYCLES=0 ----
        req  = 1'b1;
        addr = 32'h1002;
        tick();                                   // RD
        req  = 1'b0;
        chk("t4_rd_maddr", 32'(maddr_v[0]), 32'h0);
        chk("t4_rd_mis",   32'(mis_v[0]),   32'h0);
        tick();                                   // RESP
        chk("t4_ack",   32'(ack_v[0]), 32'h1);
        chk("t4_instr", ins_v[0],      32'hA5A5_0000);
        chk("t4_mis",   32'(mis_v[0]), 32'h1);
        tick();                                   // IDLE
        chk("t4_idle_mis", 32'(mis_v[0]), 32'h0);
        chk("t4_idle_ack", 32'(ack_v[0]), 32'h0);
        repeat (20) tick();

        // ---- drop req and change addr during WAIT, WAIT_CYCLES=3 ----
        clr();
        req  = 1'b1;
        addr = 32'h20;
        tick();                                   // RD
        chk("t5_rd_maddr", 32'(maddr_v[2]), 32'h8);
        tick();                                   // WAIT cnt=3
        req  = 1'b0;
        addr = 32'h40;
        tick();                                   // WAIT cnt=2
        tick();                                   // WAIT cnt=1
        chk("t5_wait_ack",   32'(ack_v[2]),   32'h0);
        chk("t5_wait_maddr", 32'(maddr_v[2]), 32'h8);
        tick();                                   // RESP
        chk("t5_ack",   32'(ack_v[2]), 32'h1);
        chk("t5_instr", ins_v[2],      32'hA5A5_0008);
        tick();                                   // IDLE
        chk("t5_idle_ack", 32'(ack_v[2]), 32'h0);
        repeat (20) tick();
        chk("t5_re_count",  32'(re_cnt[2]),  32'h1);
        chk("t5_ack_count", 32'(ack_cnt[2]), 32'h1);

        // ---- reset while transactions are in flight ----
        req  = 1'b1;
        addr = 32'h8;
        tick();                                   // RD
        req  = 1'b0;
        tick();                                   // WAIT_CYCLES=1 in WAIT
        tick();                                   // WAIT_CYCLES=1 in RESP, 15 in WAIT
        chk("t6_pre_ack", 32'(ack_v[1]), 32'h1);
        resetn = 1'b0;
        #1;
        chk("t6_async_ack",     32'(ack_v[1]), 32'h0);
        chk("t6_async_instr",   ins_v[1],      NOP);
        chk("t6_async_instr15", ins_v[3],      NOP);
        tick();
        tick();
        resetn = 1'b1;
        clr();
        repeat (25) tick();
        chk("t6_no_ack15", 32'(ack_cnt[3]), 32'h0);
        chk("t6_no_re15",  32'(re_cnt[3]),  32'h0);
        chk("t6_no_ack1",  32'(ack_cnt[1]), 32'h0);
        chk("t6_nop_held", ins_v[3],        NOP);
        req  = 1'b1;
        addr = 32'h4;
        tick();
        req  = 1'b0;
        repeat (20) tick();
        chk("t6_post_ack15",   32'(ack_cnt[3]), 32'h1);
        chk("t6_post_re15",    32'(re_cnt[3]),  32'h1);
        chk("t6_post_instr15", ins_v[3],        32'hA5A5_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nf_i_mem_resp.md
Name: nf_i_mem_resp

Overview:
- Responder end of the instruction-fetch request/acknowledge interface: receives `req_i` and the fetch address from the fetch unit.
- Reads the word from a synchronous instruction RAM with configurable wait states, then returns `req_ack_i` together with the instruction word.
- Sits between the core fetch port and the instruction memory macro.
- `req_ack_i` low is the fetch side's "no instruction this cycle" indication.

Parameters:
ADDR_W, 10, word-index width of instruction RAM (depth = 2**ADDR_W words)
WAIT_CYCLES, 1, extra RAM read latency in cycles beyond one (legal 0..15)
NOP_INSTR, 32'h00000013, value of instr_i after reset (addi x0,x0,0)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_i  input  1  fetch request from fetch unit
addr_i  input  32  fetch byte address (pc)
req_ack_i  output  1  one-cycle acknowledge; instr_i valid in the same cycle
instr_i  output  32  fetched instruction word
misalign_o  output  1  high with req_ack_i when captured addr[1:0] != 0
mem_re  output  1  RAM read enable
mem_addr  output  ADDR_W  RAM word address
mem_rd_data  input  32  RAM read data; valid WAIT_CYCLES+1 cycles after mem_re, held until next mem_re

Behaviour:
- One clock `clk`; reset `resetn` is asynchronous, active-low. All state is cleared immediately on `resetn` low.
- Reset values:
  - state = IDLE, `req_ack_i` = 0, `mem_re` = 0, `misalign_o` = 0
  - `instr_hold` = NOP_INSTR, so `instr_i` = NOP_INSTR
  - `addr_r` = 0, `cnt` = 0
- States: IDLE, RD, WAIT, RESP.
- IDLE: if `req_i`, latch `addr_i` into `addr_r` and go to RD; otherwise stay.
- RD:
  - `mem_re` = 1; `mem_addr` = `addr_r[ADDR_W+1:2]`.
  - Load `cnt` = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: decrement `cnt`; when `cnt` == 1, go to RESP.
- RESP:
  - `req_ack_i` = 1; `instr_i` = `mem_rd_data` (combinational pass-through).
  - `instr_hold` <= `mem_rd_data`; `misalign_o` = (`addr_r[1:0]` != 0).
  - If `req_i`, latch `addr_i` and go to RD (back-to-back). Otherwise go to IDLE.
- Outside RESP:
  - `req_ack_i` = 0, `misalign_o` = 0, `instr_i` = `instr_hold` (last fetched word stays stable).
  - `mem_re` = 1 only in RD; `mem_addr` = `addr_r[ADDR_W+1:2]` at all times.
- Timing:
  - Latency: `req_i` first sampled high at edge E gives RESP in cycle E + 2 + WAIT_CYCLES.
  - Sustained throughput: one ack per WAIT_CYCLES + 2 cycles.
- Address rules:
  - Address is captured only in IDLE or RESP. Changes on `addr_i` during RD/WAIT are ignored.
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
  - Misaligned addresses still read the containing word (low two bits dropped) and flag `misalign_o`.
- Request handling:
  - `req_i` deasserted during RD/WAIT: the transaction is not aborted; RESP and the ack still occur, then the block returns to IDLE.
  - `req_i` held permanently high (fetch unit ties it high) is serviced continuously.
- Reset mid-transaction: the transaction is discarded with no ack. `instr_i` returns to NOP_INSTR, and the first post-reset ack requires a new request sampled in IDLE.
- WAIT_CYCLES = 0: the WAIT state is unreachable.
- `cnt` is 4 bits wide.

Test Plan:
- WAIT_CYCLES=1, reset release, `req_i`=1 with `addr_i`=0x8, RAM word 2 = 0x00500093 -> `mem_re` pulses once with `mem_addr`=2; `req_ack_i`=1 exactly 3 cycles after the first sampled request with `instr_i`=0x00500093; `instr_i` holds that value afterwards.
- `req_i` tied high, `addr_i` stepping 0, 4, 8, WAIT_CYCLES=0 -> acks every 2 cycles returning words 0, 1, 2 in order; `instr_i` stays NOP_INSTR (0x00000013) before the first ack.
- Sweep WAIT_CYCLES over 0, 1, 3, 15 -> ack spacing is 2, 3, 5, 17 cycles; exactly one `mem_re` per ack.
- `addr_i`=0x1002 with ADDR_W=10 -> `mem_addr`=0x000 (wrap) and word 0 returned; `misalign_o`=1 only in the ack cycle.
- Drop `req_i` in WAIT, and change `addr_i` in WAIT -> ack still occurs with data from the originally captured address, then IDLE, then no further `mem_re`.
- Assert `resetn`=0 during WAIT -> `req_ack_i`=0 and `instr_i`=0x00000013 immediately; no ack until the next request after release.
